// File: rtl/bp_me_wormhole_packet_assembler.sv
// Receive-side wormhole endpoint: gathers header-first flits into one
// header-on-LSB packet buffer and hands it to the coherence endpoint.
module bp_me_wormhole_packet_assembler #(
    parameter int unsigned flit_width_p        = 17,
    parameter int unsigned x_cord_width_p      = 4,
    parameter int unsigned y_cord_width_p      = 4,
    parameter int unsigned len_width_p         = 2,
    parameter int unsigned max_num_flit_p      = 3,
    parameter int unsigned max_payload_width_p = 40,
    localparam int unsigned packet_width_lp    = x_cord_width_p + y_cord_width_p
                                               + len_width_p + max_payload_width_p
) (
    input  logic                           clk_i,
    input  logic                           reset_i,

    input  logic [flit_width_p-1:0]        data_i,
    input  logic                           v_i,
    output logic                           ready_o,

    output logic [packet_width_lp-1:0]     packet_o,
    output logic [max_payload_width_p-1:0] payload_o,
    output logic                           v_o,
    input  logic                           ready_i,

    output logic                           error_o
);

    // One extra counter bit so that len = 2^len_width_p-1 cannot wrap.
    localparam int unsigned CNT_W   = len_width_p + 1;
    localparam int unsigned LEN_LSB = x_cord_width_p + y_cord_width_p;
    localparam int unsigned PAY_LSB = x_cord_width_p + y_cord_width_p + len_width_p;
    localparam int unsigned IDX_W   = $clog2(packet_width_lp);

    localparam logic [CNT_W-1:0]       MAX_FLIT_C = CNT_W'(max_num_flit_p);
    localparam logic [len_width_p-1:0] MAX_LEN_C  = len_width_p'(max_num_flit_p - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FULL = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q,   cnt_d;
    logic [len_width_p-1:0]     len_q,   len_d;
    logic [packet_width_lp-1:0] buf_q,   buf_d;

    logic                       ready_c;
    logic                       flit_xfer_c;
    logic [len_width_p-1:0]     hdr_len_c;
    logic                       wr_en_c;
    logic [CNT_W-1:0]           wr_slot_c;

    // Len field as it would appear if data_i is a header flit.
    assign hdr_len_c = data_i[LEN_LSB +: len_width_p];

    // Flits are refused while holding a finished packet and while in reset.
    assign ready_c     = ~reset_i & (state_q != S_FULL);
    assign flit_xfer_c = v_i & ready_c;

    // Next-state, slot selection and buffer update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        buf_d     = buf_q;
        wr_en_c   = 1'b0;
        wr_slot_c = '0;

        unique case (state_q)
            S_IDLE: begin
                if (flit_xfer_c) begin
                    // Stale upper bits from a longer earlier packet must not leak.
                    buf_d     = '0;
                    wr_en_c   = 1'b1;
                    wr_slot_c = '0;
                    len_d     = hdr_len_c;
                    cnt_d     = CNT_W'(1);
                    state_d   = (hdr_len_c == '0) ? S_FULL : S_BUSY;
                end
            end
            S_BUSY: begin
                if (flit_xfer_c) begin
                    // Flits beyond the buffer (overlength packets) are consumed but dropped.
                    wr_en_c   = (cnt_q < MAX_FLIT_C);
                    wr_slot_c = cnt_q;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == {1'b0, len_q}) begin
                        state_d = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Place the flit into its slot; the last slot is truncated at the packet width.
        for (int unsigned s = 0; s < max_num_flit_p; s++) begin
            if (wr_en_c && (wr_slot_c == CNT_W'(s))) begin
                for (int unsigned b = 0; b < flit_width_p; b++) begin
                    if ((s * flit_width_p + b) < packet_width_lp) begin
                        buf_d[IDX_W'(s * flit_width_p + b)] = data_i[b];
                    end
                end
            end
        end
    end

    // State, counter, len and packet buffer registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            buf_q   <= buf_d;
        end
    end

    assign ready_o   = ready_c;
    assign v_o       = (state_q == S_FULL);
    assign packet_o  = buf_q;
    assign payload_o = buf_q[PAY_LSB +: max_payload_width_p];

    // Header flit announcing more flits than the buffer holds.
    assign error_o = ~reset_i & (state_q == S_IDLE) & v_i & (hdr_len_c > MAX_LEN_C);

    // A presented packet is held until the consumer takes it.
    a_v_hold : assert property (@(posedge clk_i) disable iff (reset_i)
        (v_o && !ready_i) |=> v_o);

    a_pkt_stable : assert property (@(posedge clk_i) disable iff (reset_i)
        (v_o && !ready_i) |=> $stable(packet_o));

endmodule

// File: tb/tb_bp_me_wormhole_packet_assembler.sv
// Bench for the wormhole packet assembler: directed flit streams, a
// queue-based packet model checked every cycle, plus literal expectations.
module tb_bp_me_wormhole_packet_assembler;

    localparam int unsigned F  = 17;
    localparam int unsigned X  = 4;
    localparam int unsigned Y  = 4;
    localparam int unsigned L  = 2;
    localparam int unsigned M  = 3;
    localparam int unsigned P  = 40;
    localparam int unsigned PW = X + Y + L + P;

    logic          clk_i;
    logic          reset_i;
    logic [F-1:0]  data_i;
    logic          v_i;
    logic          ready_o;
    logic [PW-1:0] packet_o;
    logic [P-1:0]  payload_o;
    logic          v_o;
    logic          ready_i;
    logic          error_o;

    int checks   = 0;
    int failures = 0;

    bp_me_wormhole_packet_assembler #(
        .flit_width_p       (F),
        .x_cord_width_p     (X),
        .y_cord_width_p     (Y),
        .len_width_p        (L),
        .max_num_flit_p     (M),
        .max_payload_width_p(P)
    ) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .data_i   (data_i),
        .v_i      (v_i),
        .ready_o  (ready_o),
        .packet_o (packet_o),
        .payload_o(payload_o),
        .v_o      (v_o),
        .ready_i  (ready_i),
        .error_o  (error_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- packet-level model ----------------
    logic [F-1:0]  m_flits[$];
    int            m_len     = 0;
    bit            m_full    = 1'b0;
    bit            m_started = 1'b0;
    bit            m_took    = 1'b0;
    logic [PW-1:0] m_pkt     = '0;

    always @(posedge clk_i) begin
        logic [M*F-1:0] wide;
        m_took = 1'b0;
        if (reset_i) begin
            m_started = 1'b1;
            m_flits.delete();
            m_full = 1'b0;
            m_len  = 0;
            m_pkt  = '0;
        end else if (m_started) begin
            if (m_full) begin
                if (ready_i) m_full = 1'b0;
            end else if (v_i) begin
                if (m_flits.size() == 0) m_len = int'(data_i[X+Y +: L]);
                m_flits.push_back(data_i);
                m_took = 1'b1;
                if (m_flits.size() == m_len + 1) begin
                    wide = '0;
                    for (int i = 0; i < m_flits.size() && i < int'(M); i++)
                        wide[i*F +: F] = m_flits[i];
                    m_pkt  = wide[PW-1:0];
                    m_full = 1'b1;
                    m_flits.delete();
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int            vo_cnt   = 0;
    int            err_cnt  = 0;
    logic [PW-1:0] last_pkt = '0;
    logic [P-1:0]  last_pay = '0;

    always @(negedge clk_i) begin
        bit m_idle;
        bit exp_err;
        if (m_started) begin
            m_idle  = !m_full && (m_flits.size() == 0);
            exp_err = !reset_i && m_idle && v_i && (data_i[X+Y +: L] > L'(M - 1));
            check("ready_o", 64'(ready_o), 64'(!reset_i && !m_full));
            check("v_o", 64'(v_o), 64'(m_full));
            check("error_o", 64'(error_o), 64'(exp_err));
            if (m_full) begin
                check("packet_o", 64'(packet_o), 64'(m_pkt));
                check("payload_o", 64'(payload_o), 64'(m_pkt[X+Y+L +: P]));
            end
            if (v_o) begin
                vo_cnt++;
                last_pkt = packet_o;
                last_pay = payload_o;
            end
            if (error_o) err_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_take(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_took && n < 50);
        check("flit_accepted", 64'(m_took), 64'(1));
    endtask

    task automatic send_flit(input logic [F-1:0] d);
        int n;
        v_i    = 1'b1;
        data_i = d;
        wait_take(n);
        v_i    = 1'b0;
    endtask

    logic [PW-1:0] pkt_a;
    logic [PW-1:0] pkt_b;
    logic [F-1:0]  a0, a1, a2, b0, b1, b2;
    int            vo_base;
    int            err_base;
    int            n_wait;

    initial begin
        pkt_a = 50'h2_9448_D159_E253;  // payload A5_1234_5678, len 2, y 5, x 3
        pkt_b = 50'h0_3FB7_2EA6_1E97;  // payload 0F_EDCB_A987, len 2, y 9, x 7
        a0 = pkt_a[16:0];  a1 = pkt_a[33:17];  a2 = F'(pkt_a[49:34]);
        b0 = pkt_b[16:0];  b1 = pkt_b[33:17];  b2 = F'(pkt_b[49:34]);

        v_i     = 1'b0;
        data_i  = '0;
        ready_i = 1'b1;
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;

        // Reset then idle
        @(negedge clk_i);
        check("rst_v_o", 64'(v_o), 64'(0));
        check("rst_ready_o", 64'(ready_o), 64'(1));
        check("rst_error_o", 64'(error_o), 64'(0));
        tick();
        @(negedge clk_i);
        check("rst_packet_o", 64'(packet_o), 64'(0));
        tick();

        // 3-flit packet, back-to-back, consumer always ready
        vo_base = vo_cnt;
        send_flit(a0);
        send_flit(a1);
        send_flit(a2);
        @(negedge clk_i);
        check("a_v_rise", 64'(v_o), 64'(1));
        repeat (3) tick();
        check("a_vo_cycles", 64'(vo_cnt - vo_base), 64'(1));
        check("a_packet", 64'(last_pkt), 64'(pkt_a));
        check("a_payload", 64'(last_pay), 64'(40'hA5_1234_5678));

        // Backpressure, next header (single-flit, len 0) waiting
        ready_i = 1'b0;
        send_flit(a0);
        send_flit(a1);
        send_flit(a2);
        v_i    = 1'b1;
        data_i = 17'h1_C421;
        repeat (5) begin
            @(negedge clk_i);
            check("bp_ready_o", 64'(ready_o), 64'(0));
            check("bp_packet", 64'(packet_o), 64'(pkt_a));
        end
        ready_i = 1'b1;
        wait_take(n_wait);
        check("bp_hdr_wait", 64'(n_wait), 64'(2));
        v_i = 1'b0;

        // Single-flit packet: upper bits cleared despite earlier data
        @(negedge clk_i);
        check("s_v_o", 64'(v_o), 64'(1));
        check("s_packet", 64'(packet_o), 64'(50'h1_C421));
        repeat (2) tick();

        // Bubbles between flits
        vo_base = vo_cnt;
        send_flit(b0);
        repeat (2) tick();
        send_flit(b1);
        repeat (2) tick();
        send_flit(b2);
        repeat (3) tick();
        check("b_vo_cycles", 64'(vo_cnt - vo_base), 64'(1));
        check("b_packet", 64'(last_pkt), 64'(pkt_b));

        // Mid-packet reset, then a fresh packet
        vo_base = vo_cnt;
        send_flit(a0);
        send_flit(a1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        send_flit(b0);
        send_flit(b1);
        send_flit(b2);
        repeat (3) tick();
        check("r_vo_cycles", 64'(vo_cnt - vo_base), 64'(1));
        check("r_packet", 64'(last_pkt), 64'(pkt_b));

        // Overlength: len 3 with room for 3 flits, 4th flit dropped
        vo_base  = vo_cnt;
        err_base = err_cnt;
        send_flit(17'h0_0312);
        send_flit(17'h1_1111);
        send_flit(17'h0_2222);
        send_flit(17'h1_FFFF);
        @(negedge clk_i);
        check("o_v_rise", 64'(v_o), 64'(1));
        repeat (3) tick();
        check("o_err_pulses", 64'(err_cnt - err_base), 64'(1));
        check("o_vo_cycles", 64'(vo_cnt - vo_base), 64'(1));
        check("o_packet", 64'(last_pkt), 64'(50'h0_888A_2222_0312));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
